// File: rtl/demux_tdm_one_four.sv
// demux_tdm_one_four: rebuilds four parallel channels from a TDM word stream.
// A frame is four beats (slot 0 flagged by sof). Words for slots 0..2 are
// held in a shadow bank, and d0..d3 all update together on the slot-3 beat.
// Optional feature: define DEMUX_ERR_CNT_EN to add an 8-bit saturating
// sync_err counter on port err_cnt.
//
// state | meaning
// HUNT  | waiting for a beat with sof to align to slot 0
// LOCK  | aligned; each beat is placed by the expected slot index
module demux_tdm_one_four #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
`ifdef DEMUX_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       slot_q, slot_nxt;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
  logic [WIDTH-1:0] d0_nxt, d1_nxt, d2_nxt, d3_nxt;
  logic             fv_nxt, se_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next-state and datapath decisions for the current beat
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_q;
    sh0_nxt   = sh0;
    sh1_nxt   = sh1;
    sh2_nxt   = sh2;
    d0_nxt    = d0;
    d1_nxt    = d1;
    d2_nxt    = d2;
    d3_nxt    = d3;
    fv_nxt    = 1'b0;
    se_nxt    = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            sh0_nxt   = din;
            slot_nxt  = 2'd1;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sof && slot_q != 2'd0) begin
            // Early sof: abandon the partial frame and restart on this beat
            se_nxt   = 1'b1;
            sh0_nxt  = din;
            slot_nxt = 2'd1;
          end else if (!sof && slot_q == 2'd0) begin
            se_nxt    = 1'b1;
            slot_nxt  = 2'd0;
            state_nxt = HUNT;
          end else if (slot_q == 2'd3) begin
            d0_nxt   = sh0;
            d1_nxt   = sh1;
            d2_nxt   = sh2;
            d3_nxt   = din;
            fv_nxt   = 1'b1;
            slot_nxt = 2'd0;
          end else begin
            case (slot_q)
              2'd0:    sh0_nxt = din;
              2'd1:    sh1_nxt = din;
              default: sh2_nxt = din;
            endcase
            slot_nxt = slot_q + 2'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Datapath registers: slot, shadow bank, channel outputs and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q      <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      slot_q      <= slot_nxt;
      sh0         <= sh0_nxt;
      sh1         <= sh1_nxt;
      sh2         <= sh2_nxt;
      d0          <= d0_nxt;
      d1          <= d1_nxt;
      d2          <= d2_nxt;
      d3          <= d3_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= se_nxt;
    end
  end

  // Outputs decoded from state
  always_comb begin
    locked = (state == LOCK);
    slot   = slot_q;
  end

`ifdef DEMUX_ERR_CNT_EN
  // Saturating count of sync_err pulses, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)                        err_cnt <= '0;
    else if (se_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux_tdm_one_four.sv
// Testbench for demux_tdm_one_four: directed framing scenarios followed by
// randomized beats, all compared against a frame-level reference model.
module tb_demux_tdm_one_four;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       frame_valid, sync_err, locked;
  logic [1:0] slot;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  demux_tdm_one_four #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
`ifdef DEMUX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .frame_valid(frame_valid), .sync_err(sync_err),
    .locked(locked), .slot(slot)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: alignment flag, expected slot, partial frame, outputs
  bit         m_locked;
  int         m_slot;
  logic [3:0] m_part [4];
  logic [3:0] m_d [4];
  bit         m_fv, m_se;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_locked = 0; m_slot = 0; m_fv = 0; m_se = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) begin m_part[i] = '0; m_d[i] = '0; end
    end else begin
      m_fv = 0; m_se = 0;
      if (din_valid) begin
        if (!m_locked) begin
          if (sof) begin m_part[0] = din; m_slot = 1; m_locked = 1; end
        end else if (sof && m_slot != 0) begin
          m_se = 1; m_part[0] = din; m_slot = 1;
        end else if (!sof && m_slot == 0) begin
          m_se = 1; m_locked = 0; m_slot = 0;
        end else begin
          m_part[m_slot] = din;
          if (m_slot == 3) begin
            for (int i = 0; i < 4; i++) m_d[i] = m_part[i];
            m_fv = 1;
            m_slot = 0;
          end else begin
            m_slot++;
          end
        end
      end
      if (m_se && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_all();
    check("data", {16'h0, d0, d1, d2, d3}, {16'h0, m_d[0], m_d[1], m_d[2], m_d[3]});
    check("frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
    check("sync_err", {31'h0, sync_err}, {31'h0, m_se});
    check("locked", {31'h0, locked}, {31'h0, m_locked});
    check("slot", {30'h0, slot}, m_slot);
    check("pulse_excl", {31'h0, frame_valid & sync_err}, 32'h0);
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt", {24'h0, err_cnt}, m_cnt);
`endif
  endtask

  task automatic beat(input logic v, input logic s, input logic [3:0] w, input logic r);
    @(negedge clk);
    rst_n = r; din_valid = v; sof = s; din = w;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 4'($urandom), 1'b1);
  endtask

  initial begin
    // Reset held two cycles while inputs toggle
    beat(1'b1, 1'b1, 4'($urandom), 1'b0);
    beat(1'b1, 1'b0, 4'($urandom), 1'b0);
    check("rst_data", {16'h0, d0, d1, d2, d3}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);

    // Contiguous frame
    beat(1'b1, 1'b1, 4'b1110, 1'b1);
    beat(1'b1, 1'b0, 4'b1010, 1'b1);
    beat(1'b1, 1'b0, 4'b1011, 1'b1);
    check("t2_hold", {16'h0, d0, d1, d2, d3}, 32'h0);
    beat(1'b1, 1'b0, 4'b0010, 1'b1);
    check("t2_data", {16'h0, d0, d1, d2, d3}, 32'hEAB2);
    check("t2_fv", {31'h0, frame_valid}, 32'h1);
    idle(1);
    check("t2_fv_drop", {31'h0, frame_valid}, 32'h0);

    // Gapped frame, different words so the update is visible
    beat(1'b1, 1'b1, 4'b0001, 1'b1); idle(3);
    beat(1'b1, 1'b0, 4'b0010, 1'b1); idle(3);
    beat(1'b1, 1'b0, 4'b0011, 1'b1); idle(3);
    check("t3_hold", {16'h0, d0, d1, d2, d3}, 32'hEAB2);
    beat(1'b1, 1'b0, 4'b0100, 1'b1);
    check("t3_data", {16'h0, d0, d1, d2, d3}, 32'h1234);

    // Early sof on the third beat
    beat(1'b1, 1'b1, 4'b0111, 1'b1);
    beat(1'b1, 1'b0, 4'b0110, 1'b1);
    beat(1'b1, 1'b1, 4'b1000, 1'b1);
    check("t4_err", {31'h0, sync_err}, 32'h1);
    beat(1'b1, 1'b0, 4'b1010, 1'b1);
    beat(1'b1, 1'b0, 4'b0110, 1'b1);
    check("t4_hold", {16'h0, d0, d1, d2, d3}, 32'h1234);
    beat(1'b1, 1'b0, 4'b0111, 1'b1);
    check("t4_data", {16'h0, d0, d1, d2, d3}, 32'h8A67);

    // Missing sof after a good frame, then relock
    beat(1'b1, 1'b1, 4'h5, 1'b1);
    beat(1'b1, 1'b0, 4'h6, 1'b1);
    beat(1'b1, 1'b0, 4'h7, 1'b1);
    beat(1'b1, 1'b0, 4'h8, 1'b1);
    beat(1'b1, 1'b0, 4'b1100, 1'b1);
    check("t5_err", {31'h0, sync_err}, 32'h1);
    check("t5_unlock", {31'h0, locked}, 32'h0);
    check("t5_hold", {16'h0, d0, d1, d2, d3}, 32'h5678);
    beat(1'b1, 1'b0, 4'h3, 1'b1);
    beat(1'b1, 1'b1, 4'h9, 1'b1);
    beat(1'b1, 1'b0, 4'hA, 1'b1);
    beat(1'b1, 1'b0, 4'hB, 1'b1);
    beat(1'b1, 1'b0, 4'hC, 1'b1);
    check("t5_relock", {16'h0, d0, d1, d2, d3}, 32'h9ABC);

`ifdef DEMUX_ERR_CNT_EN
    // Repeated sof keeps producing early-sof errors while locked
    for (int i = 0; i < 301; i++) beat(1'b1, 1'b1, 4'($urandom), 1'b1);
    check("t6_sat", {24'h0, err_cnt}, 32'd255);
    beat(1'b1, 1'b1, 4'($urandom), 1'b0);
    check("t6_clr", {24'h0, err_cnt}, 32'd0);
`endif

    // Randomized beats: mostly well-framed, with occasional framing faults
    for (int i = 0; i < 3000; i++) begin
      logic v, s, r;
      v = ($urandom_range(0, 9) < 7);
      s = (m_slot == 0);
      if ($urandom_range(0, 19) == 0) s = ~s;
      r = ($urandom_range(0, 299) != 0);
      beat(v, s, 4'($urandom), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
